// File: rtl/cu_data_write_engine_control_if.sv
// Shared types for the data write engine and its bus bundle.
// Read lines in, write commands/data out, plus buffer status.
package cu_data_write_engine_control_pkg;
  localparam int ARRAY_SIZE_BITS = 32;
  localparam int CACHELINE_ARRAY_NUM = 16;

  localparam logic [7:0] DATA_READ_CONTROL_ID = 8'h11;
  localparam logic [7:0] DATA_WRITE_CONTROL_ID = 8'h12;

  localparam logic [12:0] WRITE_NA = 13'h0D00;
  localparam logic [12:0] WRITE_MS = 13'h0D60;

  localparam logic [2:0] STRICT = 3'd0;
  localparam logic [2:0] ABORT = 3'd1;
  localparam logic [2:0] PAGE = 3'd2;
  localparam logic [2:0] PREF = 3'd3;
  localparam logic [2:0] SPEC = 3'd7;

  typedef enum logic [1:0] {
    CMD_INVALID,
    CMD_READ,
    CMD_WRITE
  } command_type;

  typedef enum logic [1:0] {
    STRUCT_INVALID,
    READ_DATA,
    WRITE_DATA
  } array_struct_type;

  typedef struct packed {
    logic [7:0] cu_id;
    command_type cmd_type;
    array_struct_type array_struct;
    logic [ARRAY_SIZE_BITS-1:0] real_size;
    logic [63:0] address_offest;
    logic [2:0] abt;
  } CommandTagLine;

  typedef struct packed {
    logic valid;
    CommandTagLine cmd;
    logic [511:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic valid;
    logic [12:0] command;
    logic [63:0] address;
    logic [11:0] size;
    logic [2:0] abt;
    CommandTagLine cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic [ARRAY_SIZE_BITS-1:0] real_size;
  } ResponseTag;

  typedef struct packed {
    logic valid;
    ResponseTag cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic empty;
    logic full;
    logic alfull;
  } BufferStatus;

  typedef struct packed {
    logic valid;
    logic [63:0] array_receive;
    logic [ARRAY_SIZE_BITS-1:0] size_send;
    logic [63:0] afu_config;
  } WEDInterface;

  function automatic logic [2:0] map_CABT(input logic [2:0] cfg);
    case (cfg)
      3'd0: return STRICT;
      3'd1: return ABORT;
      3'd2: return PAGE;
      3'd3: return PREF;
      3'd4: return SPEC;
      default: return STRICT;
    endcase
  endfunction

  // elements are 8 bytes wide
  function automatic logic [11:0] cmd_size_calculate(
    input logic [ARRAY_SIZE_BITS-1:0] real_size
  );
    return {real_size[8:0], 3'b000};
  endfunction
endpackage

interface cu_data_write_engine_control_if;
  import cu_data_write_engine_control_pkg::*;

  WEDInterface wed_request_in;
  ReadWriteDataLine read_data_0_in;
  ReadWriteDataLine read_data_1_in;
  ResponseBufferLine write_response_in;
  BufferStatus write_command_buffer_status;
  BufferStatus write_data_buffer_status;
  BufferStatus data_in_buffer_status;
  CommandBufferLine write_command_out;
  ReadWriteDataLine write_data_0_out;
  ReadWriteDataLine write_data_1_out;

  modport slave (
    input wed_request_in,
    input read_data_0_in,
    input read_data_1_in,
    input write_response_in,
    input write_command_buffer_status,
    input write_data_buffer_status,
    output data_in_buffer_status,
    output write_command_out,
    output write_data_0_out,
    output write_data_1_out
  );

  modport master (
    output wed_request_in,
    output read_data_0_in,
    output read_data_1_in,
    output write_response_in,
    output write_command_buffer_status,
    output write_data_buffer_status,
    input data_in_buffer_status,
    input write_command_out,
    input write_data_0_out,
    input write_data_1_out
  );
endinterface

// File: rtl/cu_data_write_engine_control.sv
// Buffers returned read lines and issues one write command per line
// to the WED receive array; counts responses to signal job done.
module cu_data_write_engine_control
  import cu_data_write_engine_control_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int ALFULL_MARGIN = 4,
  parameter logic [7:0] CU_ID = DATA_WRITE_CONTROL_ID
) (
  input logic clock,
  input logic rstn,
  input logic enabled_in,
  cu_data_write_engine_control_if.slave bus,
  output logic [ARRAY_SIZE_BITS-1:0] write_job_counter_done,
  output logic write_job_done,
  output logic overflow_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ALF_LVL = (AW+1)'(FIFO_DEPTH - ALFULL_MARGIN);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WED,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_n;
  logic enabled_q;
  WEDInterface wed_q;
  ReadWriteDataLine rd0_q, rd1_q;
  ReadWriteDataLine mem0 [FIFO_DEPTH];
  ReadWriteDataLine mem1 [FIFO_DEPTH];
  ReadWriteDataLine head0, head1;
  CommandBufferLine cmd_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [ARRAY_SIZE_BITS-1:0] issued;
  logic active, start_job, push_req, push, pop;
  logic fifo_empty, fifo_full, fifo_alfull;
  logic unused_ok;

  assign unused_ok = ^{wed_q.valid, wed_q.afu_config[63:4],
    bus.write_command_buffer_status.empty,
    bus.write_command_buffer_status.full,
    bus.write_data_buffer_status.empty,
    bus.write_data_buffer_status.full};

  assign fifo_empty = (count == '0);
  assign fifo_full = (count == FULL_LVL);
  assign fifo_alfull = (count >= ALF_LVL);
  assign bus.data_in_buffer_status = '{
    empty: fifo_empty, full: fifo_full, alfull: fifo_alfull};

  assign active = enabled_q && (state_q == RUN || state_q == DRAIN);
  assign start_job = enabled_q && state_q == IDLE;

  assign push_req = active && rd0_q.valid && rd1_q.valid
    && rd0_q.cmd.cu_id == DATA_READ_CONTROL_ID
    && rd1_q.cmd.cu_id == DATA_READ_CONTROL_ID
    && issued != wed_q.size_send;
  assign pop = active && !fifo_empty
    && !bus.write_command_buffer_status.alfull
    && !bus.write_data_buffer_status.alfull;
  // a full FIFO still accepts a push when a pop frees a slot
  assign push = push_req && (!fifo_full || pop);

  always_comb begin
    state_n = state_q;
    if (!enabled_q) begin
      if (state_q == DONE) state_n = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_n = WAIT_WED;
        WAIT_WED:
          if (bus.wed_request_in.valid)
            state_n = (bus.wed_request_in.size_send == '0) ? DONE : RUN;
        RUN: if (issued == wed_q.size_send) state_n = DRAIN;
        DRAIN:
          if (write_job_counter_done == wed_q.size_send) state_n = DONE;
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    head0 = mem0[rd_ptr];
    head1 = mem1[rd_ptr];
    cmd_n = '0;
    cmd_n.valid = 1'b1;
    cmd_n.command = wed_q.afu_config[3] ? WRITE_MS : WRITE_NA;
    cmd_n.abt = map_CABT(wed_q.afu_config[2:0]);
    cmd_n.address = wed_q.array_receive + head0.cmd.address_offest;
    cmd_n.size = cmd_size_calculate(head0.cmd.real_size);
    cmd_n.cmd.cu_id = CU_ID;
    cmd_n.cmd.cmd_type = CMD_WRITE;
    cmd_n.cmd.array_struct = WRITE_DATA;
    cmd_n.cmd.real_size = head0.cmd.real_size;
    cmd_n.cmd.address_offest = head0.cmd.address_offest;
    cmd_n.cmd.abt = cmd_n.abt;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem0[wr_ptr] <= rd0_q;
      mem1[wr_ptr] <= rd1_q;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      enabled_q <= 1'b0;
      wed_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      issued <= '0;
      write_job_counter_done <= '0;
      write_job_done <= 1'b0;
      overflow_error <= 1'b0;
      bus.write_command_out <= '0;
      bus.write_data_0_out <= '0;
      bus.write_data_1_out <= '0;
    end else begin
      state_q <= state_n;
      enabled_q <= enabled_in;
      rd0_q <= bus.read_data_0_in;
      rd1_q <= bus.read_data_1_in;
      if (enabled_q && state_q == WAIT_WED && bus.wed_request_in.valid)
        wed_q <= bus.wed_request_in;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10: count <= count + (AW+1)'(1);
        2'b01: count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop) overflow_error <= 1'b1;
      if (start_job) issued <= '0;
      else if (pop) issued <= issued + head0.cmd.real_size;
      if (start_job) write_job_counter_done <= '0;
      else if (state_q != IDLE && bus.write_response_in.valid)
        write_job_counter_done <= write_job_counter_done
          + bus.write_response_in.cmd.real_size;
      if (start_job) write_job_done <= 1'b0;
      else if (state_n == DONE && state_q != DONE) write_job_done <= 1'b1;
      if (pop) begin
        bus.write_command_out <= cmd_n;
        bus.write_data_0_out <= head0;
        bus.write_data_1_out <= head1;
      end else begin
        bus.write_command_out <= '0;
        bus.write_data_0_out <= '0;
        bus.write_data_1_out <= '0;
      end
    end
  end
endmodule
